// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch front end: issues word-aligned fetches under a credit limit,
// buffers {pc, instr} pairs in a circular queue and flushes on EX redirects.
module instr_prefetch_unit #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         imem_req_valid,
  output logic [ADDR_W-1:0]            imem_req_addr,
  input  logic                         imem_req_ready,
  input  logic                         imem_resp_valid,
  input  logic [INSTR_W-1:0]           imem_resp_data,
  output logic                         out_valid,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [INSTR_W-1:0]           out_instr,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int                PW      = $clog2(DEPTH);
  localparam int                CW      = $clog2(DEPTH+1);
  localparam logic [CW:0]       DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] resp_pc_reg, resp_pc_next;
  logic [CW-1:0]     inflight_reg, inflight_next;
  logic [CW-1:0]     drop_cnt_reg, drop_cnt_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic [CW:0]       credit_sum;
  logic              req_allowed;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic [CW-1:0]     inflight_dec;
  logic [ADDR_W-1:0] target_pc;

  // Credits count both buffered entries and kept in-flight responses, so a push
  // can never find the queue full.
  always_comb begin
    credit_sum  = {1'b0, count_reg} + {1'b0, inflight_reg} - {1'b0, drop_cnt_reg};
    req_allowed = rst && !redirect_valid && (credit_sum < DEPTH_C)
                  && ({1'b0, inflight_reg} < DEPTH_C);
  end

  assign imem_req_valid = req_allowed;
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = req_allowed && imem_req_ready;
  assign push           = imem_resp_valid && (drop_cnt_reg == '0) && !redirect_valid;
  assign out_valid      = (count_reg != '0);
  assign pop            = out_valid && out_ready && !redirect_valid;
  assign target_pc      = redirect_pc & ~ADDR_W'(3);
  assign inflight_dec   = inflight_reg - CW'(imem_resp_valid);

  assign out_pc    = out_valid ? pc_mem[rd_ptr_reg]    : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr_reg] : '0;
  assign level     = count_reg;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    resp_pc_next  = resp_pc_reg;
    inflight_next = inflight_reg;
    drop_cnt_next = drop_cnt_reg;
    count_next    = count_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    if (redirect_valid) begin
      // Everything still outstanding (bar a response landing now) is stale.
      fetch_pc_next = target_pc;
      resp_pc_next  = target_pc;
      inflight_next = inflight_dec;
      drop_cnt_next = inflight_dec;
      count_next    = '0;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
    end else begin
      if (req_fire) fetch_pc_next = fetch_pc_reg + PC_STEP;
      inflight_next = inflight_dec + CW'(req_fire);
      if (imem_resp_valid && (drop_cnt_reg != '0)) drop_cnt_next = drop_cnt_reg - CW'(1);
      if (push) begin
        resp_pc_next = resp_pc_reg + PC_STEP;
        wr_ptr_next  = wr_ptr_reg + PW'(1);
      end
      if (pop) rd_ptr_next = rd_ptr_reg + PW'(1);
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_reg <= RESET_PC;
      resp_pc_reg  <= RESET_PC;
      inflight_reg <= '0;
      drop_cnt_reg <= '0;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      resp_pc_reg  <= resp_pc_next;
      inflight_reg <= inflight_next;
      drop_cnt_reg <= drop_cnt_next;
      count_reg    <= count_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
    end
  end

  // Queue payload needs no reset: it is only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= resp_pc_reg;
      instr_mem[wr_ptr_reg] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit with an in-order, fixed-latency memory model.
module tb_instr_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;
  logic [2:0]  level;

  int tests = 0;
  int fails = 0;
  int lat   = 1;
  int cyc   = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_pc_log[$];

  instr_prefetch_unit #(.DEPTH(4), .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
    .level(level)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hA5C3_0F1E;
  endfunction

  // Memory: capture handshakes and pops on the rising edge.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      pend.delete();
    end else begin
      if (imem_resp_valid && pend.size() > 0) void'(pend.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back('{imem_req_addr, cyc + lat});
        req_log.push_back(imem_req_addr);
      end
      if (out_valid && out_ready && !redirect_valid) pop_pc_log.push_back(out_pc);
    end
    cyc = cyc + 1;
  end

  // Memory: present the oldest due response on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // Leaves the bench just after reset release on a falling edge (cycle 0).
  task automatic do_reset(input int l, input logic ordy);
    @(negedge clk);
    rst = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    out_ready = ordy;
    lat = l;
    req_log.delete();
    pop_pc_log.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL rst_level: got %0d expected 0", level); end
    tests++; if ({out_pc, out_instr} !== 64'h0) begin fails++; $display("FAIL rst_out_data: got %h expected 0", {out_pc, out_instr}); end
    rst = 1'b1;
    #1;
    tests++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
      fails++; $display("FAIL rst_first_req: got %b/%h expected 1/00000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_stream;
    do_reset(1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      tests++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'(4*k)}) begin
        fails++; $display("FAIL stream_req c%0d: got %b/%h expected 1/%h", k, imem_req_valid, imem_req_addr, 32'(4*k)); end
      if (k >= 2) begin
        tests++; if ({out_valid, out_pc, out_instr, level} !== {1'b1, 32'(4*(k-2)), mem_word(32'(4*(k-2))), 3'd1}) begin
          fails++; $display("FAIL stream_out c%0d: got v%b pc %h ins %h lvl %0d expected pc %h", k, out_valid, out_pc, out_instr, level, 32'(4*(k-2))); end
      end else begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_early c%0d: got %b expected 0", k, out_valid); end
      end
    end
  endtask

  task automatic test_full_stall;
    do_reset(1, 1'b0);
    repeat (10) @(negedge clk);
    #1;
    tests++; if (req_log.size() !== 4) begin fails++; $display("FAIL stall_req_count: got %0d expected 4", req_log.size()); end
    for (int i = 0; i < 4 && i < req_log.size(); i++) begin
      tests++; if (req_log[i] !== 32'(4*i)) begin fails++; $display("FAIL stall_req_addr%0d: got %h expected %h", i, req_log[i], 32'(4*i)); end
    end
    tests++; if ({level, imem_req_valid, out_pc} !== {3'd4, 1'b0, 32'h0}) begin
      fails++; $display("FAIL stall_full: got lvl %0d rv %b pc %h expected 4/0/0", level, imem_req_valid, out_pc); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    tests++; if (req_log.size() !== 5) begin fails++; $display("FAIL stall_one_more: got %0d expected 5", req_log.size()); end
    tests++; if (req_log.size() > 4 && req_log[4] !== 32'h10) begin fails++; $display("FAIL stall_addr4: got %h expected 00000010", req_log[4]); end
    tests++; if ({pop_pc_log.size() == 1, level} !== {1'b1, 3'd4}) begin
      fails++; $display("FAIL stall_pop: got pops %0d lvl %0d expected 1/4", pop_pc_log.size(), level); end
  endtask

  task automatic test_redirect_flush;
    do_reset(3, 1'b1);
    @(negedge clk);
    @(negedge clk); imem_req_ready = 1'b0;
    @(negedge clk); imem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    tests++; if ({out_valid, out_pc, imem_resp_valid} !== {1'b1, 32'h4, 1'b0}) begin
      fails++; $display("FAIL flush_pre: got v%b pc %h resp %b expected 1/00000004/0", out_valid, out_pc, imem_resp_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    #1;
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL flush_req_low: got %b expected 0", imem_req_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    tests++; if ({imem_req_valid, imem_req_addr, out_valid, level} !== {1'b1, 32'h100, 1'b0, 3'd0}) begin
      fails++; $display("FAIL flush_t1: got rv %b addr %h ov %b lvl %0d expected 1/00000100/0/0", imem_req_valid, imem_req_addr, out_valid, level); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_gap%0d: got %b pc %h expected 0", k, out_valid, out_pc); end
    end
    @(negedge clk); #1;
    tests++; if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
      fails++; $display("FAIL flush_first: got v%b pc %h ins %h expected 1/00000100/%h", out_valid, out_pc, out_instr, mem_word(32'h100)); end
    @(negedge clk); #1;
    tests++; if (out_pc !== 32'h104) begin fails++; $display("FAIL flush_second: got %h expected 00000104", out_pc); end
  endtask

  task automatic test_redirect_collide;
    do_reset(2, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    tests++; if ({out_valid, out_pc, imem_resp_valid} !== {1'b1, 32'h8, 1'b1}) begin
      fails++; $display("FAIL coll_pre: got v%b pc %h resp %b expected 1/00000008/1", out_valid, out_pc, imem_resp_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    tests++; if ({imem_req_valid, imem_req_addr, out_valid, level} !== {1'b1, 32'h200, 1'b0, 3'd0}) begin
      fails++; $display("FAIL coll_t1: got rv %b addr %h ov %b lvl %0d expected 1/00000200/0/0", imem_req_valid, imem_req_addr, out_valid, level); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL coll_stale%0d: got %b pc %h expected 0", k, out_valid, out_pc); end
    end
    @(negedge clk); #1;
    tests++; if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h200, mem_word(32'h200)}) begin
      fails++; $display("FAIL coll_first: got v%b pc %h ins %h expected 1/00000200/%h", out_valid, out_pc, out_instr, mem_word(32'h200)); end
    @(negedge clk); #1;
    tests++; if (out_pc !== 32'h204) begin fails++; $display("FAIL coll_second: got %h expected 00000204", out_pc); end
  endtask

  task automatic test_ready_stall;
    do_reset(1, 1'b1);
    repeat (3) @(negedge clk);
    imem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      tests++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hC}) begin
        fails++; $display("FAIL hold c%0d: got %b/%h expected 1/0000000c", k, imem_req_valid, imem_req_addr); end
    end
    @(negedge clk);
    imem_req_ready = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    tests++; if (req_log.size() < 12) begin fails++; $display("FAIL hold_req_count: got %0d expected >=12", req_log.size()); end
    for (int i = 0; i < req_log.size(); i++) begin
      tests++; if (req_log[i] !== 32'(4*i)) begin fails++; $display("FAIL hold_seq%0d: got %h expected %h", i, req_log[i], 32'(4*i)); end
    end
    for (int i = 0; i < pop_pc_log.size(); i++) begin
      tests++; if (pop_pc_log[i] !== 32'(4*i)) begin fails++; $display("FAIL hold_out%0d: got %h expected %h", i, pop_pc_log[i], 32'(4*i)); end
    end
  endtask

  task automatic test_reset_mid;
    bit found = 1'b0;
    do_reset(1, 1'b0);
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk); #1;
      if (level == 3'd3) found = 1'b1;
    end
    tests++; if (found !== 1'b1) begin fails++; $display("FAIL mid_level3: got %0d expected 3", level); end
    #2;
    rst = 1'b0;
    #1;
    tests++; if ({out_valid, imem_req_valid, level, out_pc, out_instr} !== {1'b0, 1'b0, 3'd0, 64'h0}) begin
      fails++; $display("FAIL mid_async: got ov %b rv %b lvl %0d pc %h expected 0/0/0/0", out_valid, imem_req_valid, level, out_pc); end
    req_log.delete();
    pop_pc_log.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if ({imem_req_valid, imem_req_addr, out_valid} !== {1'b1, 32'h0, 1'b0}) begin
      fails++; $display("FAIL mid_restart: got %b/%h ov %b expected 1/00000000/0", imem_req_valid, imem_req_addr, out_valid); end
    repeat (4) @(negedge clk);
    #1;
    tests++; if (req_log.size() < 2 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4) begin
      fails++; $display("FAIL mid_seq: got %0d reqs first %h expected 0,4", req_log.size(), req_log.size() > 0 ? req_log[0] : 32'hx); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_full_stall;
    test_redirect_flush;
    test_redirect_collide;
    test_ready_stall;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
